// File: rtl/lsu_ctrl_pkg.sv
// Shared constants for the load/store unit: RISC-V funct3 size codes, default widths,
// and small decode helpers used by the controller.
package lsu_ctrl_pkg;

   localparam int DATAWIDTH_DEF = 32;
   localparam int ADDR_W_DEF    = 10;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   function automatic logic op_illegal(input logic store, input logic [2:0] f3);
      if (store)
         return f3 > F3_W;
      else
         return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

   // Only meaningful for legal ops; byte accesses can never be misaligned.
   function automatic logic op_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_H, F3_HU: return a[0];
         F3_W:        return a != 2'd0;
         default:     return 1'b0;
      endcase
   endfunction

   // Index of the final byte of an access of this size.
   function automatic logic [1:0] op_last_byte(input logic [2:0] f3);
      case (f3)
         F3_H, F3_HU: return 2'd1;
         F3_W:        return 2'd3;
         default:     return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// Load result assembly: picks each byte lane from the live memory word or from bytes
// captured during a split access, then sign/zero extends according to funct3.
module lsu_load_align
   import lsu_ctrl_pkg::*;
#(
   parameter int datawidth = DATAWIDTH_DEF
) (
   input  logic [2:0]           funct3,
   input  logic                 split,
   input  logic [1:0]           last_idx,
   input  logic [datawidth-1:0] raw,
   input  logic [datawidth-1:0] capt,
   output logic [datawidth-1:0] rdata
);

   localparam int NB = datawidth / 8;

   logic [datawidth-1:0] word;

   // In a split access the final byte arrives on dataOut[7:0] in the response cycle.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         assign word[8*gi +: 8] = !split                ? raw[8*gi +: 8] :
                                  (2'(gi) == last_idx)  ? raw[7:0]       :
                                                          capt[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      rdata = word;
      case (funct3)
         F3_B:    rdata = {{(datawidth-8){word[7]}}, word[7:0]};
         F3_H:    rdata = {{(datawidth-16){word[15]}}, word[15:0]};
         F3_BU:   rdata = {{(datawidth-8){1'b0}}, word[7:0]};
         F3_HU:   rdata = {{(datawidth-16){1'b0}}, word[15:0]};
         default: rdata = word;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one memory op, drives the data-memory strobes,
// and returns a single-cycle response. Define LSU_MISALIGN_SPLIT_EN to split misaligned
// halfword/word ops into ascending byte accesses instead of flagging them.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int datawidth = DATAWIDTH_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_store,
   input  logic [2:0]           req_funct3,
   input  logic [31:0]          req_addr,
   input  logic [datawidth-1:0] req_wdata,
   output logic                 MemWrite,
   output logic                 MemRead,
   output logic [2:0]           funct3,
   output logic [ADDR_W-1:0]    dataAddr,
   output logic [datawidth-1:0] dataIn,
   input  logic [datawidth-1:0] dataOut,
   output logic                 rsp_valid,
   output logic [datawidth-1:0] rsp_rdata,
   output logic                 rsp_misaligned,
   output logic                 rsp_illegal
);

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t               state_reg, state_next;
   logic                 store_reg, store_next;
   logic [2:0]           f3_reg, f3_next;
   logic [ADDR_W-1:0]    addr_reg, addr_next;
   logic [datawidth-1:0] wdata_reg, wdata_next;
   logic                 mis_reg, mis_next;
   logic                 ill_reg, ill_next;
   logic                 split_reg, split_next;
   logic [1:0]           last_reg, last_next;
   logic [1:0]           cnt_reg, cnt_next;
   logic [datawidth-1:0] capt_reg, capt_next;

   logic                 accept;
   logic                 req_ill;
   logic                 req_mis;
   logic [1:0]           prev_idx;
   logic [datawidth-1:0] align_rdata;
   logic                 unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:ADDR_W];

   assign req_ill  = op_illegal(req_store, req_funct3);
   assign req_mis  = !req_ill && op_misaligned(req_funct3, req_addr[1:0]);
   assign accept   = req_valid && req_ready;
   assign prev_idx = cnt_reg - 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         store_reg <= 1'b0;
         f3_reg    <= '0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         mis_reg   <= 1'b0;
         ill_reg   <= 1'b0;
         split_reg <= 1'b0;
         last_reg  <= '0;
         cnt_reg   <= '0;
         capt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         store_reg <= store_next;
         f3_reg    <= f3_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         mis_reg   <= mis_next;
         ill_reg   <= ill_next;
         split_reg <= split_next;
         last_reg  <= last_next;
         cnt_reg   <= cnt_next;
         capt_reg  <= capt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      store_next = store_reg;
      f3_next    = f3_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      mis_next   = mis_reg;
      ill_next   = ill_reg;
      split_next = split_reg;
      last_next  = last_reg;
      cnt_next   = cnt_reg;
      capt_next  = capt_reg;

      case (state_reg)
         ST_IDLE, ST_RESP: begin
            state_next = ST_IDLE;
            if (accept) begin
               store_next = req_store;
               f3_next    = req_funct3;
               addr_next  = req_addr[ADDR_W-1:0];
               wdata_next = req_wdata;
               ill_next   = req_ill;
               mis_next   = req_mis && !SPLIT_EN;
               split_next = req_mis && SPLIT_EN;
               last_next  = (req_mis && SPLIT_EN) ? op_last_byte(req_funct3) : 2'd0;
               cnt_next   = 2'd0;
               // Errors skip the memory entirely and answer in the very next cycle.
               if (req_ill || (req_mis && !SPLIT_EN))
                  state_next = ST_RESP;
               else
                  state_next = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // dataOut now holds the byte read in the previous split cycle.
            if (split_reg && !store_reg && cnt_reg != 2'd0)
               capt_next[{prev_idx, 3'b000} +: 8] = dataOut[7:0];
            if (cnt_reg == last_reg)
               state_next = ST_RESP;
            else
               cnt_next = cnt_reg + 2'd1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   lsu_load_align #(
      .datawidth (datawidth)
   ) u_align (
      .funct3   (f3_reg),
      .split    (split_reg),
      .last_idx (last_reg),
      .raw      (dataOut),
      .capt     (capt_reg),
      .rdata    (align_rdata)
   );

   always_comb begin
      req_ready      = (state_reg == ST_IDLE || state_reg == ST_RESP) && !rst;
      MemRead        = (state_reg == ST_ACCESS) && !rst && !store_reg;
      MemWrite       = (state_reg == ST_ACCESS) && !rst && store_reg;
      funct3         = split_reg ? (store_reg ? F3_B : F3_BU) : f3_reg;
      dataAddr       = addr_reg + ADDR_W'(cnt_reg);
      dataIn         = split_reg ? datawidth'(wdata_reg[{cnt_reg, 3'b000} +: 8]) : wdata_reg;
      rsp_valid      = (state_reg == ST_RESP) && !rst;
      rsp_misaligned = rsp_valid && mis_reg;
      rsp_illegal    = rsp_valid && ill_reg;
      rsp_rdata      = (rsp_valid && !store_reg && !mis_reg && !ill_reg) ? align_rdata : '0;
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl: a byte-array data memory drives the DUT,
// while a separate reference byte array predicts every response value and its cycle.
module tb_lsu_ctrl;

   localparam int DW = 32;
   localparam int AW = 10;

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic          clk, rst;
   logic          req_valid, req_ready, req_store;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [DW-1:0] req_wdata;
   logic          MemWrite, MemRead;
   logic [2:0]    funct3;
   logic [AW-1:0] dataAddr;
   logic [DW-1:0] dataIn, dataOut;
   logic          rsp_valid, rsp_misaligned, rsp_illegal;
   logic [DW-1:0] rsp_rdata;

   lsu_ctrl #(.datawidth(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .MemWrite(MemWrite), .MemRead(MemRead), .funct3(funct3),
      .dataAddr(dataAddr), .dataIn(dataIn), .dataOut(dataOut),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_misaligned(rsp_misaligned), .rsp_illegal(rsp_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] rdata;
      bit          mis;
      bit          ill;
      int          acc;
   } exp_t;

   exp_t       q[$];
   logic [7:0] dmem[1024];
   logic [7:0] rmem[1024];
   bit         mem_init;
   int         strobe_cnt, both_cnt, exp_strobes;
   int         cyc, n_checks, n_fail;

   function automatic int nbytes(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   // Data memory: returns the addressed bytes right-justified, junk above them.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) dmem[i] <= 8'(i * 37 + 5);
      end else begin
         if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
         if (MemRead || MemWrite) strobe_cnt <= strobe_cnt + 1;
         if (MemWrite)
            for (int k = 0; k < nbytes(funct3); k++)
               dmem[(int'(dataAddr) + k) % 1024] <= dataIn[8*k +: 8];
      end
      if (MemRead) begin
         logic [31:0] v;
         v = $urandom;
         for (int k = 0; k < nbytes(funct3); k++)
            v[8*k +: 8] = dmem[(int'(dataAddr) + k) % 1024];
         dataOut <= v;
      end else begin
         dataOut <= $urandom;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_rsp();
      exp_t e;
      if (rsp_valid) begin
         if (q.size() == 0) begin
            check("rsp_spurious", 1, 0);
         end else begin
            e = q.pop_front();
            check("rsp_cycle", cyc, e.due);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_misaligned", rsp_misaligned, e.mis);
            check("rsp_illegal", rsp_illegal, e.ill);
            exp_strobes += e.acc;
         end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         check("rsp_missing", 0, 1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_rsp();
   endtask

   // Presents one op, waits for acceptance and predicts its response from rmem.
   task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
      exp_t        e;
      int          n;
      bit          ill, mis;
      logic [31:0] v;
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      for (int w = 0; w < 20 && !req_ready; w++) tick();
      if (!req_ready) begin
         check("req_ready_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      n   = nbytes(f3);
      mis = !ill && (int'(addr[1:0]) % n) != 0;
      e.due = cyc; e.rdata = 0; e.mis = 0; e.ill = ill; e.acc = 0;
      if (ill) begin
         e.due += 1;
      end else if (mis && !SPLIT) begin
         e.due += 1;
         e.mis = 1;
      end else begin
         e.acc = mis ? n : 1;
         e.due += 1 + e.acc;
         v = 0;
         for (int k = 0; k < n; k++) begin
            if (st) rmem[(int'(addr[9:0]) + k) % 1024] = wd[8*k +: 8];
            else    v[8*k +: 8] = rmem[(int'(addr[9:0]) + k) % 1024];
         end
         if (!st) begin
            case (f3)
               3'd0:    e.rdata = {{24{v[7]}}, v[7:0]};
               3'd1:    e.rdata = {{16{v[15]}}, v[15:0]};
               3'd4:    e.rdata = {24'd0, v[7:0]};
               3'd5:    e.rdata = {16'd0, v[15:0]};
               default: e.rdata = v;
            endcase
         end
      end
      q.push_back(e);
      $display("txn %s f3=%0d addr=%h wdata=%h accepted@%0d rsp@%0d exp_rdata=%h mis=%0d ill=%0d",
               st ? "ST" : "LD", f3, addr, wd, cyc, e.due, e.rdata, e.mis, e.ill);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int w = 0; w < 20 && q.size() != 0; w++) tick();
      if (q.size() != 0) begin
         check("drain_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   initial begin
      cyc = 0; n_checks = 0; n_fail = 0;
      strobe_cnt = 0; both_cnt = 0; exp_strobes = 0;
      mem_init = 1'b1;
      rst = 1'b1; req_valid = 1'b0; req_store = 1'b0;
      req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      for (int i = 0; i < 1024; i++) rmem[i] = 8'(i * 37 + 5);
      @(negedge clk);
      mem_init = 1'b0;
      tick(); tick();
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_memread", MemRead, 0);
      check("rst_memwrite", MemWrite, 0);
      check("rst_rdata", rsp_rdata, 0);
      rst = 1'b0;
      tick();
      check("post_rst_ready", req_ready, 1);
      check("post_rst_rsp_valid", rsp_valid, 0);

      // Word store then load back.
      issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      check("sw_memwrite", MemWrite, 1);
      check("sw_addr", dataAddr, 32'h10);
      drain();
      issue(1'b0, 3'd2, 32'h10, 32'h0);
      check("lw_memread", MemRead, 1);
      drain();

      // Byte store with sign vs zero extension on reload.
      issue(1'b1, 3'd0, 32'h21, 32'h80);
      drain();
      issue(1'b0, 3'd0, 32'h21, 32'h0);
      drain();
      issue(1'b0, 3'd4, 32'h21, 32'h0);
      drain();

      // Misaligned word load: split into bytes or rejected outright.
      issue(1'b0, 3'd2, 32'h13, 32'h0);
      if (SPLIT) begin
         for (int k = 0; k < 4; k++) begin
            check("split_memread", MemRead, 1);
            check("split_addr", dataAddr, 32'h13 + k);
            check("split_funct3", funct3, 3'd4);
            if (k < 3) tick();
         end
      end else begin
         check("mis_no_strobe", MemRead, 0);
      end
      drain();

      // Illegal load funct3.
      issue(1'b0, 3'd3, 32'h0, 32'h0);
      check("ill_no_read", MemRead, 0);
      drain();

      // Back-to-back aligned loads accepted in RESP.
      for (int i = 0; i < 4; i++) issue(1'b0, 3'd2, 32'h10 + 4 * i, 32'h0);
      drain();

      // Reset while an op is in flight.
      issue(1'b0, 3'd2, 32'h13, 32'h0);
      rst = 1'b1;
      q.delete();
      tick();
      check("rst_flight_memread", MemRead, 0);
      check("rst_flight_memwrite", MemWrite, 0);
      check("rst_flight_rsp", rsp_valid, 0);
      rst = 1'b0;
      tick();
      check("rst_flight_ready", req_ready, 1);
      check("rst_flight_no_rsp", rsp_valid, 0);

      // Random traffic with random idle gaps.
      for (int i = 0; i < 250; i++) begin
         logic [31:0] a;
         a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) a = a | 32'h3FC;
         issue(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end
      drain();
      tick(); tick();

      check("strobe_count", strobe_cnt, exp_strobes);
      check("both_strobes", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
